// File: rtl/fetch_stage_if.sv
// Instruction-memory request/ready port between the fetch stage (master) and imem (slave).
interface fetch_stage_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, addr, input rdata, ready);
  modport slave  (input req, addr, output rdata, ready);
endinterface

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC, imem request/ready port, IF/ID register, stall/branch/trap redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Pipe_stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        UndefInst,
  fetch_stage_if.master imem,
  output logic [31:0] Inst,
  output logic [31:0] PCPlus4,
  output logic        InstValid,
  output logic [31:0] PC
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state;
  logic [31:0] skid;
  logic        pend;
  logic [31:0] pend_tgt;
  logic        redir;
  logic [31:0] tgt;
  logic [31:0] pc_inc;

  // Trap wins over branch and is taken even while decode is stalled.
  assign redir  = UndefInst | (BranchTaken & ~Pipe_stall);
  assign tgt    = (UndefInst ? EXC_VECTOR : BranchTarget) & ~32'd3;
  assign pc_inc = PC + 32'd4;

  assign imem.req  = (state == FETCH);
  assign imem.addr = PC & ~32'd3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      PC        <= RESET_PC;
      Inst      <= NOP_INST;
      PCPlus4   <= 32'd0;
      InstValid <= 1'b0;
      skid      <= 32'd0;
      pend      <= 1'b0;
      pend_tgt  <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state <= FETCH;
          if (redir) PC <= tgt;
        end
        FETCH: begin
          if (imem.ready) begin
            if (redir || pend) begin
              // Word in flight belongs to the squashed path; a fresh redirect beats a pending one.
              PC        <= redir ? tgt : pend_tgt;
              pend      <= 1'b0;
              Inst      <= NOP_INST;
              InstValid <= 1'b0;
            end else if (!Pipe_stall) begin
              Inst      <= imem.rdata;
              PCPlus4   <= pc_inc;
              InstValid <= 1'b1;
              PC        <= pc_inc;
            end else begin
              skid  <= imem.rdata;
              state <= HOLD;
            end
          end else begin
            // Address must stay put until the outstanding beat returns, so remember the target.
            if (redir) begin
              pend     <= 1'b1;
              pend_tgt <= tgt;
            end
            if (!Pipe_stall) begin
              Inst      <= NOP_INST;
              InstValid <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (redir) begin
            PC        <= tgt;
            Inst      <= NOP_INST;
            InstValid <= 1'b0;
            state     <= FETCH;
          end else if (!Pipe_stall) begin
            Inst      <= skid;
            PCPlus4   <= pc_inc;
            InstValid <= 1'b1;
            PC        <= pc_inc;
            state     <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an address-hashed imem model and an IF/ID scoreboard.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall, bt, undef;
  logic [31:0] btgt;
  logic [31:0] inst, pc4, pc;
  logic        vld;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc4;
    logic        vld;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  fetch_stage_if imem();

  function automatic logic [31:0] w(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem.rdata = w(imem.addr);

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .EXC_VECTOR(32'h0000_0080),
    .NOP_INST  (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .Pipe_stall  (stall),
    .BranchTaken (bt),
    .BranchTarget(btgt),
    .UndefInst   (undef),
    .imem        (imem),
    .Inst        (inst),
    .PCPlus4     (pc4),
    .InstValid   (vld),
    .PC          (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p4, input logic v,
                      input logic [31:0] p);
    exp_t e;
    e.inst = i; e.pc4 = p4; e.vld = v; e.pc = p;
    sb.push_back(e);
  endtask

  // Bubbles leave PCPlus4 unspecified, so it is only compared for valid entries.
  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".inst"}, inst, e.inst);
    chk({tag, ".vld"}, {31'd0, vld}, {31'd0, e.vld});
    chk({tag, ".pc"}, pc, e.pc);
    if (e.vld) chk({tag, ".pc4"}, pc4, e.pc4);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; bt = 1'b0; undef = 1'b0; btgt = 32'd0;
    imem.ready = 1'b1;
    #12;
    chk("rst.inst", inst, 32'd0);
    chk("rst.pc4", pc4, 32'd0);
    chk("rst.vld", {31'd0, vld}, 32'd0);
    chk("rst.pc", pc, 32'd0);
    chk("rst.req", {31'd0, imem.req}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("idle.req", {31'd0, imem.req}, 32'd0);

    // Reset release and streaming at one word per cycle
    push(32'd0, 32'd0, 1'b0, 32'd0); tick("idle");
    chk("fetch.req", {31'd0, imem.req}, 32'd1);
    chk("fetch.addr", imem.addr, 32'd0);
    push(w(32'd0), 32'd4, 1'b1, 32'd4); tick("w0");
    push(w(32'd4), 32'd8, 1'b1, 32'd8); tick("w1");

    // Stall at PC=8: word parks in the skid buffer, IF/ID frozen
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push(w(32'd4), 32'd8, 1'b1, 32'd8); tick("stall");
      chk("stall.req", {31'd0, imem.req}, 32'd0);
    end
    stall = 1'b0;
    push(w(32'd8), 32'd12, 1'b1, 32'd12); tick("unstall");
    push(w(32'd12), 32'd16, 1'b1, 32'd16); tick("w3");

    // Taken branch at PC=0x10 squashes the word fetched that cycle
    bt = 1'b1; btgt = 32'h40;
    push(32'd0, 32'd0, 1'b0, 32'h40); tick("br");
    bt = 1'b0;
    push(w(32'h40), 32'h44, 1'b1, 32'h44); tick("br_tgt");

    // Trap during stall beats a concurrent branch
    stall = 1'b1; bt = 1'b1; btgt = 32'h40; undef = 1'b1;
    push(32'd0, 32'd0, 1'b0, 32'h80); tick("trap");
    stall = 1'b0; bt = 1'b0; undef = 1'b0;
    push(w(32'h80), 32'h84, 1'b1, 32'h84); tick("trap_tgt");

    // Slow memory with a branch arriving while the beat is outstanding
    imem.ready = 1'b0;
    push(32'd0, 32'd0, 1'b0, 32'h84); tick("wait1");
    chk("wait1.addr", imem.addr, 32'h84);
    bt = 1'b1; btgt = 32'h200;
    push(32'd0, 32'd0, 1'b0, 32'h84); tick("wait2");
    bt = 1'b0;
    chk("wait2.addr", imem.addr, 32'h84);
    for (int k = 0; k < 2; k++) begin
      push(32'd0, 32'd0, 1'b0, 32'h84); tick("wait34");
      chk("wait34.addr", imem.addr, 32'h84);
    end
    imem.ready = 1'b1;
    push(32'd0, 32'd0, 1'b0, 32'h200); tick("pend");
    chk("pend.addr", imem.addr, 32'h200);
    push(w(32'h200), 32'h204, 1'b1, 32'h204); tick("pend_tgt");

    // Trap while parked in HOLD drops the buffered word
    stall = 1'b1;
    push(w(32'h200), 32'h204, 1'b1, 32'h204); tick("hold_in");
    chk("hold.req", {31'd0, imem.req}, 32'd0);
    undef = 1'b1;
    push(32'd0, 32'd0, 1'b0, 32'h80); tick("hold_trap");
    undef = 1'b0; stall = 1'b0;
    chk("hold_trap.req", {31'd0, imem.req}, 32'd1);
    push(w(32'h80), 32'h84, 1'b1, 32'h84); tick("hold_tgt");

    // PC wrap at the top of the address space; target low bits forced to 0
    bt = 1'b1; btgt = 32'hFFFF_FFFF;
    push(32'd0, 32'd0, 1'b0, 32'hFFFF_FFFC); tick("br_top");
    bt = 1'b0;
    chk("top.addr", imem.addr, 32'hFFFF_FFFC);
    push(w(32'hFFFF_FFFC), 32'd0, 1'b1, 32'd0); tick("wrap");
    chk("wrap.addr", imem.addr, 32'd0);
    push(w(32'd0), 32'd4, 1'b1, 32'd4); tick("after_wrap");

    // Async reset abandons an outstanding request
    imem.ready = 1'b0;
    push(32'd0, 32'd0, 1'b0, 32'd4); tick("wait_rst");
    chk("wait_rst.req", {31'd0, imem.req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst.req", {31'd0, imem.req}, 32'd0);
    chk("arst.pc", pc, 32'd0);
    chk("arst.vld", {31'd0, vld}, 32'd0);
    @(posedge clk); #1;
    chk("arst_hold.req", {31'd0, imem.req}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
